// File: rtl/fetch_debug_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_debug_ctrl_if
// Description : Bundle of UART-side, hazard-side, instruction-RAM write and
//               fetch-stage control signals of the debug sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_debug_ctrl_if #(
  parameter int NB_BITS   = 32,
  parameter int RAM_DEPTH = 10
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic                 i_hz_stall;
  logic                 i_halt;
  logic                 o_mem_we;
  logic [RAM_DEPTH-1:0] o_mem_waddr;
  logic [NB_BITS-1:0]   o_mem_wdata;
  logic                 o_pc_we;
  logic                 o_if_id_we;
  logic                 o_cpu_rst;
  logic [2:0]           o_state;

  // Environment side: drives UART bytes and pipeline status, observes controls
  modport master (
    output i_rx_data, i_rx_valid, i_hz_stall, i_halt,
    input  o_mem_we, o_mem_waddr, o_mem_wdata, o_pc_we, o_if_id_we, o_cpu_rst, o_state
  );

  // Sequencer side
  modport slave (
    input  i_rx_data, i_rx_valid, i_hz_stall, i_halt,
    output o_mem_we, o_mem_waddr, o_mem_wdata, o_pc_we, o_if_id_we, o_cpu_rst, o_state
  );
endinterface
`default_nettype wire

// File: rtl/fetch_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_debug_ctrl
// Description : Debug-side sequencer for the MIPS fetch stage. Decodes UART
//               command bytes, assembles little-endian program words into
//               instruction RAM, and gates PC / IF-ID writes for continuous
//               run or single-step execution.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_debug_ctrl #(
  parameter int         NB_BITS   = 32,
  parameter int         RAM_DEPTH = 10,
  parameter logic [7:0] CMD_LOAD  = 8'h4C,
  parameter logic [7:0] CMD_CONT  = 8'h43,
  parameter logic [7:0] CMD_STEP  = 8'h53,
  parameter logic [7:0] CMD_RST   = 8'h52
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  fetch_debug_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_CNT  = 3'd1,
    ST_LD_DATA = 3'd2,
    ST_RUN     = 3'd3,
    ST_STEP    = 3'd4,
    ST_HALTED  = 3'd5
  } state_t;

  localparam logic [RAM_DEPTH-1:0] c_waddr_one = {{(RAM_DEPTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic                 r_run_en;
  logic                 r_mem_we;
  logic                 r_cpu_rst;
  logic [1:0]           r_byte_cnt;
  logic [7:0]           r_words_left;
  logic [RAM_DEPTH-1:0] r_waddr;
  logic [NB_BITS-1:0]   r_wdata;

  // A real pipeline advance happens only when the run gate is open and the
  // hazard unit is not holding the front end.
  wire logic w_advance = r_run_en & ~bus.i_hz_stall;
  wire logic w_rx_rst  = bus.i_rx_valid && (bus.i_rx_data == CMD_RST);

  // Command decode, program load sequencing and run/step gating
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_run_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_rst    <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_words_left <= 8'd0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      // Write strobe and CPU reset are single-cycle pulses
      r_mem_we  <= 1'b0;
      r_cpu_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              r_state <= ST_LD_CNT;
            end else if (bus.i_rx_data == CMD_CONT) begin
              r_state  <= ST_RUN;
              r_run_en <= 1'b1;
            end else if (bus.i_rx_data == CMD_STEP) begin
              r_state  <= ST_STEP;
              r_run_en <= 1'b1;
            end else if (bus.i_rx_data == CMD_RST) begin
              r_cpu_rst <= 1'b1;
            end
          end
        end
        ST_LD_CNT: begin
          // The byte after 'L' is always the word count, even if it looks like a command
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == 8'd0) begin
              r_state   <= ST_IDLE;
              r_cpu_rst <= 1'b1;
            end else begin
              r_words_left <= bus.i_rx_data;
              r_waddr      <= '0;
              r_byte_cnt   <= 2'd0;
              r_state      <= ST_LD_DATA;
            end
          end
        end
        ST_LD_DATA: begin
          // Byte k lands in lane k; the fourth byte completes the word
          if (bus.i_rx_valid) begin
            r_wdata[{r_byte_cnt, 3'b000} +: 8] <= bus.i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_mem_we <= 1'b1;
            end
          end
          // Address advances after the strobe cycle; last word restarts the CPU
          if (r_mem_we) begin
            r_waddr <= r_waddr + c_waddr_one;
            if (r_words_left == 8'd1) begin
              r_state   <= ST_IDLE;
              r_cpu_rst <= 1'b1;
            end else begin
              r_words_left <= r_words_left - 8'd1;
            end
          end
        end
        ST_RUN: begin
          // An abort from the host takes priority over a halt in the same cycle
          if (w_rx_rst) begin
            r_state   <= ST_IDLE;
            r_run_en  <= 1'b0;
            r_cpu_rst <= 1'b1;
          end else if (bus.i_halt) begin
            r_state  <= ST_HALTED;
            r_run_en <= 1'b0;
          end
        end
        ST_STEP: begin
          // Stalled cycles do not count; leave only after one real advance
          if (w_advance) begin
            r_run_en <= 1'b0;
            r_state  <= bus.i_halt ? ST_HALTED : ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (w_rx_rst) begin
            r_state   <= ST_IDLE;
            r_cpu_rst <= 1'b1;
          end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD)) begin
            r_state <= ST_LD_CNT;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_run_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_mem_waddr = r_waddr;
  assign bus.o_mem_wdata = r_wdata;
  assign bus.o_pc_we     = w_advance;
  assign bus.o_if_id_we  = w_advance;
  assign bus.o_cpu_rst   = r_cpu_rst;
  assign bus.o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_debug_ctrl
// Description : Self-checking bench for fetch_debug_ctrl. RAM writes are
//               checked against a queue of expected {addr,data} entries;
//               per-scenario tasks check state, gating and reset pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_debug_ctrl;

  localparam int NB_BITS   = 32;
  localparam int RAM_DEPTH = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  fetch_debug_ctrl_if #(.NB_BITS(NB_BITS), .RAM_DEPTH(RAM_DEPTH)) bus ();

  fetch_debug_ctrl #(.NB_BITS(NB_BITS), .RAM_DEPTH(RAM_DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_writes = 0;
  int n_rst_pulse = 0;
  int n_pcwe = 0;
  int last_we_cyc = 0;
  int last_rst_cyc = 0;
  logic [RAM_DEPTH+NB_BITS-1:0] exp_q[$];

  // Scoreboard monitor: every RAM write must match the oldest expected entry
  always @(negedge i_clk) begin
    logic [RAM_DEPTH+NB_BITS-1:0] e;
    cyc = cyc + 1;
    if (bus.o_mem_we === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 bus.o_mem_waddr, bus.o_mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_mem_waddr, bus.o_mem_wdata} !== e) begin
          n_bad = n_bad + 1;
          $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.o_mem_waddr, bus.o_mem_wdata, e[RAM_DEPTH+NB_BITS-1:NB_BITS], e[NB_BITS-1:0]);
        end
      end
      n_writes = n_writes + 1;
      last_we_cyc = cyc;
    end
    if (bus.o_cpu_rst === 1'b1) begin
      n_rst_pulse = n_rst_pulse + 1;
      last_rst_cyc = cyc;
    end
    if (bus.o_pc_we === 1'b1) n_pcwe = n_pcwe + 1;
  end

  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    step_clk();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [RAM_DEPTH-1:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(b);
    end
  endtask

  // Bounded wait for the CPU reset pulse count to exceed a snapshot
  task automatic wait_rst_pulse(input int start, input string name);
    int budget;
    budget = 0;
    while (n_rst_pulse <= start && budget < 30) begin
      step_clk();
      budget++;
    end
    @(negedge i_clk);
    n_cmp++;
    if (n_rst_pulse <= start) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d reset pulses, expected more than %0d", name, n_rst_pulse, start);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) step_clk();
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", bus.o_state); end
    n_cmp++; if (bus.o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b expected 0", bus.o_mem_we); end
    n_cmp++; if (bus.o_mem_waddr !== '0) begin n_bad++; $display("FAIL rst_waddr: got %0d expected 0", bus.o_mem_waddr); end
    n_cmp++; if (bus.o_mem_wdata !== '0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 0", bus.o_mem_wdata); end
    n_cmp++; if (bus.o_pc_we !== 1'b0 || bus.o_if_id_we !== 1'b0) begin n_bad++; $display("FAIL rst_pc_we: got %b/%b expected 0/0", bus.o_pc_we, bus.o_if_id_we); end
    n_cmp++; if (bus.o_cpu_rst !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rst: got %b expected 0", bus.o_cpu_rst); end
    step_clk();
  endtask

  task automatic test_load_two();
    int w0, p0;
    w0 = n_writes; p0 = n_rst_pulse;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_word(2'd0, 32'h11223344);
    send_word(2'd1, 32'hAABBCCDD);
    wait_rst_pulse(p0, "load2");
    n_cmp++; if (n_writes - w0 != 2) begin n_bad++; $display("FAIL load2_count: got %0d writes expected 2", n_writes - w0); end
    n_cmp++; if (last_rst_cyc != last_we_cyc + 1) begin n_bad++; $display("FAIL load2_rst_timing: got rst at %0d, expected %0d", last_rst_cyc, last_we_cyc + 1); end
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL load2_state: got %0d expected 0", bus.o_state); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL load2_pending: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_load_zero();
    int w0, p0;
    w0 = n_writes; p0 = n_rst_pulse;
    send_byte(8'h4C);
    send_byte(8'h00);
    wait_rst_pulse(p0, "load0");
    repeat (3) step_clk();
    n_cmp++; if (n_writes != w0) begin n_bad++; $display("FAIL load0_writes: got %0d writes expected 0", n_writes - w0); end
    n_cmp++; if (n_rst_pulse - p0 != 1) begin n_bad++; $display("FAIL load0_pulses: got %0d expected 1", n_rst_pulse - p0); end
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL load0_state: got %0d expected 0", bus.o_state); end
  endtask

  task automatic test_continuous();
    int p0;
    send_byte(8'h43);
    bus.i_hz_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_cmp++; if (bus.o_pc_we !== 1'b0 || bus.o_if_id_we !== 1'b0) begin n_bad++; $display("FAIL run_stall_gate: got %b/%b expected 0/0", bus.o_pc_we, bus.o_if_id_we); end
      step_clk();
    end
    bus.i_hz_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      n_cmp++; if (bus.o_pc_we !== 1'b1 || bus.o_if_id_we !== 1'b1) begin n_bad++; $display("FAIL run_open_gate: got %b/%b expected 1/1", bus.o_pc_we, bus.o_if_id_we); end
      n_cmp++; if (bus.o_state !== 3'd3) begin n_bad++; $display("FAIL run_state: got %0d expected 3", bus.o_state); end
      step_clk();
    end
    // A non-reset byte while running is ignored
    send_byte(8'h4C);
    @(negedge i_clk);
    n_cmp++; if (bus.o_state !== 3'd3) begin n_bad++; $display("FAIL run_ignore_byte: got %0d expected 3", bus.o_state); end
    bus.i_halt = 1'b1;
    step_clk();
    bus.i_halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      n_cmp++; if (bus.o_state !== 3'd5) begin n_bad++; $display("FAIL halt_state: got %0d expected 5", bus.o_state); end
      n_cmp++; if (bus.o_pc_we !== 1'b0) begin n_bad++; $display("FAIL halt_pc_we: got %b expected 0", bus.o_pc_we); end
      step_clk();
    end
    p0 = n_rst_pulse;
    send_byte(8'h52);
    @(negedge i_clk);
    n_cmp++; if (bus.o_cpu_rst !== 1'b1) begin n_bad++; $display("FAIL halt_rst_pulse: got %b expected 1", bus.o_cpu_rst); end
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL halt_rst_state: got %0d expected 0", bus.o_state); end
    step_clk();
  endtask

  task automatic test_step();
    int c0;
    c0 = n_pcwe;
    bus.i_hz_stall = 1'b1;
    send_byte(8'h53);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      n_cmp++; if (bus.o_pc_we !== 1'b0) begin n_bad++; $display("FAIL step_stall_gate: got %b expected 0", bus.o_pc_we); end
      n_cmp++; if (bus.o_state !== 3'd4) begin n_bad++; $display("FAIL step_state: got %0d expected 4", bus.o_state); end
      step_clk();
    end
    bus.i_hz_stall = 1'b0;
    repeat (5) step_clk();
    @(negedge i_clk);
    n_cmp++; if (n_pcwe - c0 != 1) begin n_bad++; $display("FAIL step_count: got %0d advance cycles expected 1", n_pcwe - c0); end
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL step_end_state: got %0d expected 0", bus.o_state); end
  endtask

  task automatic test_wrap();
    int w0, p0;
    w0 = n_writes; p0 = n_rst_pulse;
    send_byte(8'h4C);
    send_byte(8'h05);
    for (int i = 0; i < 5; i++) begin
      logic [RAM_DEPTH-1:0] a;
      a = RAM_DEPTH'(i % 4);
      send_word(a, $urandom());
    end
    wait_rst_pulse(p0, "wrap");
    n_cmp++; if (n_writes - w0 != 5) begin n_bad++; $display("FAIL wrap_count: got %0d writes expected 5", n_writes - w0); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_pending: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_rst_midload();
    int w0, p0;
    w0 = n_writes;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h52);
    send_byte(8'h22);
    i_rst = 1'b1;
    step_clk();
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (bus.o_state !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d expected 0", bus.o_state); end
    n_cmp++; if (bus.o_mem_waddr !== '0 || bus.o_mem_wdata !== '0) begin n_bad++; $display("FAIL midrst_clear: got addr=%0d data=%h expected 0/0", bus.o_mem_waddr, bus.o_mem_wdata); end
    step_clk();
    n_cmp++; if (n_writes != w0) begin n_bad++; $display("FAIL midrst_writes: got %0d writes expected 0", n_writes - w0); end
    p0 = n_rst_pulse;
    send_byte(8'h4C);
    send_byte(8'h01);
    send_word(2'd0, 32'hCAFE0152);
    wait_rst_pulse(p0, "reload");
    n_cmp++; if (n_writes - w0 != 1) begin n_bad++; $display("FAIL reload_count: got %0d writes expected 1", n_writes - w0); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL reload_pending: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_hz_stall = 1'b0;
    bus.i_halt     = 1'b0;
    test_reset();
    test_load_two();
    test_load_zero();
    test_continuous();
    test_step();
    test_wrap();
    test_rst_midload();
    repeat (3) step_clk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
